// File: rtl/io_command_initiator.sv
// Core-side initiator for the 16-bit external IO command bus.
// Queues commands, issues one at a time, returns responses via writeback ports.
module io_command_initiator #(
  parameter int          CMD_FIFO_DEPTH = 4,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [15:0] TIMEOUT_DATA   = 16'hFFFF
) (
  input  logic        clk,
  input  logic        async_rst_n,
  input  logic        clk_en,
  input  logic        Cmd_Valid,
  output logic        Cmd_Ready,
  input  logic [15:0] Cmd_Data,
  input  logic [3:0]  Cmd_DestReg,
  input  logic        Cmd_ResponseRequested,
  output logic        IO_REQ,
  input  logic        IO_ACK,
  output logic        IO_CommandEn,
  output logic        IO_ResponseRequested,
  output logic [3:0]  IO_DestRegOut,
  output logic [15:0] IO_DataOut,
  input  logic        IO_CommandResponse,
  input  logic        IO_RegResponseFlag,
  input  logic        IO_MemResponseFlag,
  input  logic [3:0]  IO_DestRegIn,
  input  logic [15:0] IO_DataIn,
  output logic        RegWB_Valid,
  input  logic        RegWB_Ready,
  output logic [3:0]  RegWB_Dest,
  output logic [15:0] RegWB_Data,
  output logic        MemWB_Valid,
  input  logic        MemWB_Ready,
  output logic [15:0] MemWB_Data,
  output logic        Busy,
  output logic        Timeout_Err
);

  localparam int PW = $clog2(CMD_FIFO_DEPTH);
  localparam int CW = $clog2(CMD_FIFO_DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  dest;
    logic        rr;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RESP,
    WB_HOLD
  } state_t;

  state_t        state;
  cmd_t          mem [CMD_FIFO_DEPTH];
  cmd_t          head;
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;
  logic [CW-1:0] count;
  logic [TW-1:0] tmr;
  logic          push;
  logic          pop;
  logic          respIn;

  assign head         = mem[rdPtr];
  assign Cmd_Ready    = count < CW'(CMD_FIFO_DEPTH);
  assign push         = Cmd_Valid && Cmd_Ready && clk_en;
  assign pop          = (state == ISSUE) && IO_ACK && clk_en;
  assign IO_CommandEn = IO_REQ;
  assign Busy         = (state != IDLE) || (count != '0);

  // Response accepted either with the ACK itself or later while waiting
  assign respIn = IO_CommandResponse &&
    (((state == ISSUE) && IO_ACK && IO_ResponseRequested) ||
     (state == WAIT_RESP));

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wrPtr] <= '{data: Cmd_Data,
                      dest: Cmd_DestReg,
                      rr:   Cmd_ResponseRequested};
    end
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PW'(1);
      if (pop)  rdPtr <= rdPtr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state                <= IDLE;
      IO_REQ               <= 1'b0;
      IO_ResponseRequested <= 1'b0;
      IO_DestRegOut        <= '0;
      IO_DataOut           <= '0;
      RegWB_Valid          <= 1'b0;
      RegWB_Dest           <= '0;
      RegWB_Data           <= '0;
      MemWB_Valid          <= 1'b0;
      MemWB_Data           <= '0;
      Timeout_Err          <= 1'b0;
      tmr                  <= '0;
    end else if (clk_en) begin
      Timeout_Err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (count != '0) begin
            state                <= ISSUE;
            IO_REQ               <= 1'b1;
            IO_DataOut           <= head.data;
            IO_DestRegOut        <= head.dest;
            IO_ResponseRequested <= head.rr;
          end
        end
        ISSUE: begin
          if (IO_ACK) begin
            IO_REQ               <= 1'b0;
            IO_ResponseRequested <= 1'b0;
            if (!IO_ResponseRequested) begin
              state <= IDLE;
            end else if (!IO_CommandResponse) begin
              state <= WAIT_RESP;
              tmr   <= TW'(TIMEOUT_CYCLES);
            end
          end
        end
        WAIT_RESP: begin
          if (!IO_CommandResponse) begin
            if (tmr == TW'(1)) begin
              state       <= WB_HOLD;
              RegWB_Valid <= 1'b1;
              RegWB_Data  <= TIMEOUT_DATA;
              RegWB_Dest  <= IO_DestRegOut;
              Timeout_Err <= 1'b1;
            end else begin
              tmr <= tmr - TW'(1);
            end
          end
        end
        WB_HOLD: begin
          if ((RegWB_Valid && RegWB_Ready) ||
              (MemWB_Valid && MemWB_Ready)) begin
            state       <= IDLE;
            RegWB_Valid <= 1'b0;
            MemWB_Valid <= 1'b0;
          end
        end
      endcase
      // Capture overrides the per-state next state above
      if (respIn) begin
        if (IO_RegResponseFlag) begin
          state       <= WB_HOLD;
          RegWB_Valid <= 1'b1;
          RegWB_Data  <= IO_DataIn;
          RegWB_Dest  <= IO_DestRegIn;
        end else if (IO_MemResponseFlag) begin
          state       <= WB_HOLD;
          MemWB_Valid <= 1'b1;
          MemWB_Data  <= IO_DataIn;
        end else begin
          state <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_io_command_initiator.sv
// Bench for io_command_initiator: vector table, issue-order scoreboard,
// and hand sequences for reset, back-pressure and clk_en stalls.
module tb_io_command_initiator;

  localparam int TO = 3;

  logic        clk = 1'b0;
  logic        async_rst_n;
  logic        clk_en;
  logic        Cmd_Valid;
  logic        Cmd_Ready;
  logic [15:0] Cmd_Data;
  logic [3:0]  Cmd_DestReg;
  logic        Cmd_ResponseRequested;
  logic        IO_REQ;
  logic        IO_ACK;
  logic        IO_CommandEn;
  logic        IO_ResponseRequested;
  logic [3:0]  IO_DestRegOut;
  logic [15:0] IO_DataOut;
  logic        IO_CommandResponse;
  logic        IO_RegResponseFlag;
  logic        IO_MemResponseFlag;
  logic [3:0]  IO_DestRegIn;
  logic [15:0] IO_DataIn;
  logic        RegWB_Valid;
  logic        RegWB_Ready;
  logic [3:0]  RegWB_Dest;
  logic [15:0] RegWB_Data;
  logic        MemWB_Valid;
  logic        MemWB_Ready;
  logic [15:0] MemWB_Data;
  logic        Busy;
  logic        Timeout_Err;

  always #5 clk = ~clk;

  io_command_initiator #(
    .CMD_FIFO_DEPTH(4),
    .TIMEOUT_CYCLES(TO),
    .TIMEOUT_DATA(16'hFFFF)
  ) dut (
    .clk(clk),
    .async_rst_n(async_rst_n),
    .clk_en(clk_en),
    .Cmd_Valid(Cmd_Valid),
    .Cmd_Ready(Cmd_Ready),
    .Cmd_Data(Cmd_Data),
    .Cmd_DestReg(Cmd_DestReg),
    .Cmd_ResponseRequested(Cmd_ResponseRequested),
    .IO_REQ(IO_REQ),
    .IO_ACK(IO_ACK),
    .IO_CommandEn(IO_CommandEn),
    .IO_ResponseRequested(IO_ResponseRequested),
    .IO_DestRegOut(IO_DestRegOut),
    .IO_DataOut(IO_DataOut),
    .IO_CommandResponse(IO_CommandResponse),
    .IO_RegResponseFlag(IO_RegResponseFlag),
    .IO_MemResponseFlag(IO_MemResponseFlag),
    .IO_DestRegIn(IO_DestRegIn),
    .IO_DataIn(IO_DataIn),
    .RegWB_Valid(RegWB_Valid),
    .RegWB_Ready(RegWB_Ready),
    .RegWB_Dest(RegWB_Dest),
    .RegWB_Data(RegWB_Data),
    .MemWB_Valid(MemWB_Valid),
    .MemWB_Ready(MemWB_Ready),
    .MemWB_Data(MemWB_Data),
    .Busy(Busy),
    .Timeout_Err(Timeout_Err)
  );

  int nChecks = 0;
  int nFails  = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] want);
    nChecks++;
    if (act !== want) begin
      nFails++;
      $display("FAIL %s: got %0h, expected %0h at %0t",
               name, act, want, $time);
    end
  endtask

  typedef struct packed {
    logic        rr;
    logic [3:0]  dest;
    logic [15:0] data;
  } cmd_t;

  cmd_t expQ[$];

  always @(negedge clk) begin
    if (async_rst_n && clk_en && Cmd_Valid && Cmd_Ready)
      expQ.push_back({Cmd_ResponseRequested, Cmd_DestReg, Cmd_Data});
  end

  always @(negedge clk) begin
    cmd_t e;
    if (async_rst_n && clk_en && IO_REQ && IO_ACK) begin
      if (expQ.size() == 0) begin
        nChecks++;
        nFails++;
        $display("FAIL issue_unexpected: got %0h, expected none at %0t",
                 IO_DataOut, $time);
      end else begin
        e = expQ.pop_front();
        chk("issue_order",
            {11'b0, IO_ResponseRequested, IO_DestRegOut, IO_DataOut},
            {11'b0, e});
      end
    end
  end

  typedef struct {
    logic [15:0] data;
    logic [3:0]  dest;
    logic        rr;
    int          ackDelay;
    logic        sameResp;
    int          respAt;
    logic        regF;
    logic        memF;
    logic [15:0] rData;
    logic [3:0]  rDest;
    int          holdCyc;
    logic        expReg;
    logic        expMem;
    logic [15:0] expData;
    logic [3:0]  expDest;
    logic        expTo;
  } vec_t;

  vec_t tbl[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setResp(input vec_t v);
    IO_CommandResponse = 1'b1;
    IO_RegResponseFlag = v.regF;
    IO_MemResponseFlag = v.memF;
    IO_DataIn          = v.rData;
    IO_DestRegIn       = v.rDest;
  endtask

  task automatic clrResp();
    IO_CommandResponse = 1'b0;
    IO_RegResponseFlag = 1'b0;
    IO_MemResponseFlag = 1'b0;
    IO_DataIn          = '0;
    IO_DestRegIn       = '0;
  endtask

  task automatic runTxn(input vec_t v);
    int   lat;
    int   w;
    bit   done;
    logic expT;
    chk("busy_idle", Busy, 0);
    Cmd_Valid             = 1'b1;
    Cmd_Data              = v.data;
    Cmd_DestReg           = v.dest;
    Cmd_ResponseRequested = v.rr;
    tick();
    lat = 1;
    Cmd_Valid = 1'b0;
    while (!IO_REQ && lat < 20) begin
      tick();
      lat++;
    end
    chk("push_to_req_latency", lat, 2);
    for (int i = 0; i < v.ackDelay; i++) begin
      chk("req_held", {IO_REQ, IO_DataOut}, {1'b1, v.data});
      tick();
    end
    chk("req_at_ack",
        {IO_REQ, IO_CommandEn, IO_DataOut, IO_DestRegOut},
        {2'b11, v.data, v.dest});
    IO_ACK = 1'b1;
    if (v.sameResp) setResp(v);
    tick();
    IO_ACK = 1'b0;
    clrResp();
    chk("req_drop", IO_REQ, 0);
    if (v.rr && !v.sameResp) begin
      w = 0;
      done = 0;
      while (!done) begin
        if (w == v.respAt) setResp(v);
        tick();
        clrResp();
        expT = v.expTo && (w == TO - 1);
        chk("timeout_pulse", Timeout_Err, expT);
        if (w == v.respAt || expT || w >= 20) done = 1;
        w++;
      end
    end
    chk("reg_valid", RegWB_Valid, v.expReg);
    chk("mem_valid", MemWB_Valid, v.expMem);
    if (v.expReg) begin
      chk("reg_data", RegWB_Data, v.expData);
      chk("reg_dest", RegWB_Dest, v.expDest);
    end
    if (v.expMem) chk("mem_data", MemWB_Data, v.expData);
    chk("busy_wb", Busy, v.expReg || v.expMem);
    if (v.expReg || v.expMem) begin
      for (int i = 0; i < v.holdCyc; i++) begin
        tick();
        chk("wb_hold",
            {RegWB_Valid, MemWB_Valid,
             v.expReg ? RegWB_Data : MemWB_Data},
            {v.expReg, v.expMem, v.expData});
        if (i == 0) chk("timeout_clear", Timeout_Err, 0);
      end
      RegWB_Ready = v.expReg;
      MemWB_Ready = v.expMem;
      tick();
      RegWB_Ready = 1'b0;
      MemWB_Ready = 1'b0;
      chk("wb_release", {RegWB_Valid, MemWB_Valid, Busy}, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tbl[0] = '{16'h6400, 4'd5, 1'b1, 0, 1'b1, 0, 1'b1, 1'b0,
               16'h0001, 4'd5, 5, 1'b1, 1'b0, 16'h0001, 4'd5, 1'b0};
    tbl[1] = '{16'h0001, 4'd0, 1'b0, 3, 1'b0, 0, 1'b0, 1'b0,
               16'h0000, 4'd0, 0, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b0};
    tbl[2] = '{16'h2002, 4'd3, 1'b0, 1, 1'b1, 0, 1'b1, 1'b0,
               16'hBEEF, 4'd3, 0, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b0};
    tbl[3] = '{16'h4005, 4'd9, 1'b1, 2, 1'b0, 1, 1'b1, 1'b0,
               16'hABCD, 4'd9, 1, 1'b1, 1'b0, 16'hABCD, 4'd9, 1'b0};
    tbl[4] = '{16'h8010, 4'd2, 1'b1, 0, 1'b0, 0, 1'b0, 1'b1,
               16'h1234, 4'd2, 2, 1'b0, 1'b1, 16'h1234, 4'd0, 1'b0};
    tbl[5] = '{16'hA0FF, 4'd6, 1'b1, 0, 1'b1, 0, 1'b1, 1'b1,
               16'h5A5A, 4'hC, 1, 1'b1, 1'b0, 16'h5A5A, 4'hC, 1'b0};
    tbl[6] = '{16'hC3C3, 4'd4, 1'b1, 1, 1'b0, 1, 1'b0, 1'b0,
               16'h7777, 4'd4, 0, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b0};
    tbl[7] = '{16'hE001, 4'd7, 1'b1, 0, 1'b0, 99, 1'b0, 1'b0,
               16'h0000, 4'd0, 2, 1'b1, 1'b0, 16'hFFFF, 4'd7, 1'b1};
    tbl[8] = '{16'h6123, 4'd8, 1'b1, 0, 1'b0, 2, 1'b1, 1'b0,
               16'h0042, 4'hB, 1, 1'b1, 1'b0, 16'h0042, 4'hB, 1'b0};
    tbl[9] = '{16'h2400, 4'd1, 1'b1, 2, 1'b1, 0, 1'b0, 1'b1,
               16'h0F0F, 4'd1, 3, 1'b0, 1'b1, 16'h0F0F, 4'd0, 1'b0};

    async_rst_n = 1'b1;
    clk_en = 1'b1;
    Cmd_Valid = 1'b0;
    Cmd_Data = '0;
    Cmd_DestReg = '0;
    Cmd_ResponseRequested = 1'b0;
    IO_ACK = 1'b0;
    RegWB_Ready = 1'b0;
    MemWB_Ready = 1'b0;
    clrResp();
    #1 async_rst_n = 1'b0;
    #2;
    chk("rst_ready", Cmd_Ready, 1);
    chk("rst_req", {IO_REQ, IO_CommandEn, IO_ResponseRequested}, 0);
    chk("rst_bus", {IO_DestRegOut, IO_DataOut}, 0);
    chk("rst_wb", {RegWB_Valid, MemWB_Valid, RegWB_Dest}, 0);
    chk("rst_wb_data", {RegWB_Data, MemWB_Data}, 0);
    chk("rst_status", {Busy, Timeout_Err}, 0);
    tick();
    tick();
    async_rst_n = 1'b1;
    tick();

    for (int k = 0; k < 10; k++) begin
      runTxn(tbl[k]);
      tick();
    end

    // back-pressure: fill the queue with no ACK, then wrap
    for (int i = 0; i < 4; i++) begin
      Cmd_Valid = 1'b1;
      Cmd_Data = 16'h1100 + 16'(i);
      Cmd_DestReg = 4'(i);
      Cmd_ResponseRequested = 1'b0;
      chk("bp_ready", Cmd_Ready, 1);
      tick();
    end
    chk("bp_full", Cmd_Ready, 0);
    Cmd_Data = 16'h1104;
    Cmd_DestReg = 4'd4;
    tick();
    chk("bp_stall", {Cmd_Ready, IO_REQ}, 2'b01);
    IO_ACK = 1'b1;
    tick();
    IO_ACK = 1'b0;
    chk("bp_ready_after_ack", Cmd_Ready, 1);
    tick();
    Cmd_Valid = 1'b0;
    chk("bp_full_again", Cmd_Ready, 0);
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!IO_REQ && n < 10) begin
        tick();
        n++;
      end
      chk("bp_req", IO_REQ, 1);
      IO_ACK = 1'b1;
      tick();
      IO_ACK = 1'b0;
    end
    tick();
    chk("bp_drained", Busy, 0);

    // clk_en stalls with a memory response held by back-pressure
    Cmd_Valid = 1'b1;
    Cmd_Data = 16'h3C00;
    Cmd_DestReg = 4'd2;
    Cmd_ResponseRequested = 1'b1;
    tick();
    Cmd_Valid = 1'b0;
    clk_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("en_hold_req", {IO_REQ, Busy}, 2'b01);
    end
    clk_en = 1'b1;
    tick();
    chk("en_issue", IO_REQ, 1);
    clk_en = 1'b0;
    IO_ACK = 1'b1;
    IO_CommandResponse = 1'b1;
    IO_MemResponseFlag = 1'b1;
    IO_DataIn = 16'h55AA;
    tick();
    chk("en_ack_ignored", {IO_REQ, MemWB_Valid, RegWB_Valid}, 3'b100);
    clk_en = 1'b1;
    tick();
    IO_ACK = 1'b0;
    clrResp();
    chk("en_mem_route", {MemWB_Valid, RegWB_Valid}, 2'b10);
    chk("en_mem_data", MemWB_Data, 16'h55AA);
    for (int i = 0; i < 5; i++) begin
      clk_en = (i % 2) == 0;
      tick();
      chk("en_wb_stable", {MemWB_Valid, RegWB_Valid, MemWB_Data},
          {2'b10, 16'h55AA});
    end
    MemWB_Ready = 1'b1;
    clk_en = 1'b0;
    tick();
    chk("en_ready_gated", MemWB_Valid, 1);
    clk_en = 1'b1;
    tick();
    MemWB_Ready = 1'b0;
    chk("en_release", {MemWB_Valid, Busy}, 0);

    // asynchronous reset in the middle of an issue
    Cmd_Valid = 1'b1;
    Cmd_Data = 16'h7001;
    Cmd_DestReg = 4'd3;
    Cmd_ResponseRequested = 1'b0;
    tick();
    Cmd_Data = 16'h7002;
    Cmd_DestReg = 4'd4;
    Cmd_ResponseRequested = 1'b1;
    tick();
    Cmd_Valid = 1'b0;
    n = 0;
    while (!IO_REQ && n < 10) begin
      tick();
      n++;
    end
    chk("rst_pre_req", IO_REQ, 1);
    #2 async_rst_n = 1'b0;
    expQ.delete();
    #1;
    chk("rst_mid_req", {IO_REQ, IO_CommandEn}, 0);
    chk("rst_mid_ready", Cmd_Ready, 1);
    chk("rst_mid_busy", Busy, 0);
    tick();
    async_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_queue_lost", {IO_REQ, Busy}, 0);
    end

    chk("scoreboard_drain", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFails);
    $finish;
  end

endmodule
